// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcodes, decode enums and the control bundle type for the decode stage
package decode_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J,
        IMM_U
    } imm_src_t;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_OR    = 3'b011,
        ALU_PASSB = 3'b100,
        ALU_SLT   = 3'b101
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    typedef struct packed {
        logic        reg_write;
        result_src_t result_src;
        logic        mem_write;
        logic        alu_src;
        logic        alu_src_a_pc;
        logic        branch;
        logic        jump;
        logic        jump_reg;
        alu_ctrl_t   alu_control;
    } ctrl_t;

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - builds the I/S/B/J/U immediate and sign-extends it to XLEN
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  imm_src_t        imm_src,
    output logic [XLEN-1:0] immext
);

    logic [31:0] imm32;

    // Assemble the 32-bit immediate for the selected format; every format is sign-extended from instr[31]
    always_comb begin
        case (imm_src)
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            default: imm32 = {{20{instr[31]}}, instr[31:20]};
        endcase
    end

    // Widen to XLEN by replicating the sign bit above bit 31
    always_comb begin
        immext       = {XLEN{imm32[31]}};
        immext[31:0] = imm32;
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I decode stage with valid/ready handshake, stall and flush
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit EN_UTYPE = 1'b1,
    parameter bit EN_JALR  = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_immext,
    output ctrl_t           out_ctrl,
    output logic            out_illegal
);

    logic [6:0]      op;
    logic [2:0]      funct3;
    logic            funct7_5;
    ctrl_t           dec_ctrl;
    imm_src_t        dec_imm_src;
    logic            dec_illegal;
    alu_ctrl_t       alu_dec;
    logic            alu_dec_bad;
    logic [XLEN-1:0] dec_immext;

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [4:0]      rs1_q;
    logic [4:0]      rs2_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] imm_q;
    ctrl_t           ctrl_q;
    logic            illegal_q;
    logic            accept;

    assign op       = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign funct7_5 = in_instr[30];

    // ALU operation for R-type and I-ALU; SUB only for R-type with funct7[5] set
    always_comb begin
        alu_dec     = ALU_ADD;
        alu_dec_bad = 1'b0;
        case (funct3)
            3'b000:  alu_dec = (op[5] && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_dec = ALU_SLT;
            3'b110:  alu_dec = ALU_OR;
            3'b111:  alu_dec = ALU_AND;
            default: alu_dec_bad = 1'b1;
        endcase
    end

    // Main decode; anything flagged illegal leaves the control bundle all-zero
    always_comb begin
        dec_ctrl    = '0;
        dec_imm_src = IMM_I;
        dec_illegal = 1'b0;
        case (op)
            OP_LOAD: begin
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.result_src = RES_MEM;
                dec_ctrl.alu_src    = 1'b1;
            end
            OP_STORE: begin
                dec_imm_src        = IMM_S;
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
            end
            OP_R: begin
                dec_ctrl.reg_write   = 1'b1;
                dec_ctrl.alu_control = alu_dec;
                dec_illegal          = alu_dec_bad;
            end
            OP_I: begin
                dec_ctrl.reg_write   = 1'b1;
                dec_ctrl.alu_src     = 1'b1;
                dec_ctrl.alu_control = alu_dec;
                dec_illegal          = alu_dec_bad;
            end
            OP_BRANCH: begin
                dec_imm_src          = IMM_B;
                dec_ctrl.branch      = 1'b1;
                dec_ctrl.alu_control = ALU_SUB;
            end
            OP_JAL: begin
                dec_imm_src         = IMM_J;
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.result_src = RES_PC4;
                dec_ctrl.jump       = 1'b1;
            end
            OP_JALR: begin
                if (EN_JALR) begin
                    dec_ctrl.reg_write  = 1'b1;
                    dec_ctrl.result_src = RES_PC4;
                    dec_ctrl.jump_reg   = 1'b1;
                    dec_ctrl.alu_src    = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_LUI: begin
                dec_imm_src = IMM_U;
                if (EN_UTYPE) begin
                    dec_ctrl.reg_write   = 1'b1;
                    dec_ctrl.alu_src     = 1'b1;
                    dec_ctrl.alu_control = ALU_PASSB;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_AUIPC: begin
                dec_imm_src = IMM_U;
                if (EN_UTYPE) begin
                    dec_ctrl.reg_write    = 1'b1;
                    dec_ctrl.alu_src      = 1'b1;
                    dec_ctrl.alu_src_a_pc = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_ctrl = '0;
        end
    end

    imm_gen #(
        .XLEN(XLEN)
    ) u_imm_gen (
        .instr  (in_instr[31:7]),
        .imm_src(dec_imm_src),
        .immext (dec_immext)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Pipeline register: reset, then flush, then accept, else drain on transfer or hold on stall
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q   <= 1'b1;
            pc_q      <= in_pc;
            rs1_q     <= in_instr[19:15];
            rs2_q     <= in_instr[24:20];
            rd_q      <= in_instr[11:7];
            imm_q     <= dec_immext;
            ctrl_q    <= dec_ctrl;
            illegal_q <= dec_illegal;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Bubbles never expose stale control or illegal flags downstream
    assign out_valid   = valid_q;
    assign out_pc      = pc_q;
    assign out_rs1     = rs1_q;
    assign out_rs2     = rs2_q;
    assign out_rd      = rd_q;
    assign out_immext  = imm_q;
    assign out_ctrl    = valid_q ? ctrl_q : '0;
    assign out_illegal = valid_q && illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage
module tb_decode_stage;
    import decode_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        chk_imm;
        ctrl_t       ctrl;
        logic        ill;
        logic        ill_nou;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [31:0] out_immext;
    ctrl_t       out_ctrl;
    logic        out_illegal;

    logic        nou_in_ready, nou_out_valid, nou_out_illegal;
    logic [31:0] nou_out_pc, nou_out_immext;
    logic [4:0]  nou_out_rs1, nou_out_rs2, nou_out_rd;
    ctrl_t       nou_out_ctrl;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t cur_exp;
    logic [31:0] pc_ctr = 32'h0000_1000;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .EN_UTYPE(1'b1), .EN_JALR(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_rd(out_rd), .out_immext(out_immext), .out_ctrl(out_ctrl), .out_illegal(out_illegal)
    );

    decode_stage #(.XLEN(32), .EN_UTYPE(1'b0), .EN_JALR(1'b1)) dut_nou (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(nou_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(nou_out_valid),
        .out_ready(out_ready), .out_pc(nou_out_pc), .out_rs1(nou_out_rs1), .out_rs2(nou_out_rs2),
        .out_rd(nou_out_rd), .out_immext(nou_out_immext), .out_ctrl(nou_out_ctrl),
        .out_illegal(nou_out_illegal)
    );

    function automatic ctrl_t mkc(logic rw, result_src_t rs, logic mw, logic as, logic apc,
                                  logic br, logic j, logic jr, alu_ctrl_t alu);
        ctrl_t c;
        c.reg_write    = rw;
        c.result_src   = rs;
        c.mem_write    = mw;
        c.alu_src      = as;
        c.alu_src_a_pc = apc;
        c.branch       = br;
        c.jump         = j;
        c.jump_reg     = jr;
        c.alu_control  = alu;
        return c;
    endfunction

    function automatic exp_t mk(logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd, logic [31:0] imm,
                                logic chk, ctrl_t c, logic ill, logic ill_nou);
        exp_t e;
        e.pc = '0; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.imm = imm;
        e.chk_imm = chk; e.ctrl = c; e.ill = ill; e.ill_nou = ill_nou;
        return e;
    endfunction

    // Scoreboard: pop on output transfer, push on accept, drop on flush/reset
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got pc=%h instr output with no pending expectation", out_pc);
                end else begin
                    e = sb.pop_front();
                    if (out_pc !== e.pc || out_rs1 !== e.rs1 || out_rs2 !== e.rs2 || out_rd !== e.rd ||
                        out_ctrl !== e.ctrl || out_illegal !== e.ill || (e.chk_imm && out_immext !== e.imm)) begin
                        errors++;
                        $display("FAIL sb_bundle: got pc=%h rs1=%0d rs2=%0d rd=%0d imm=%h ctrl=%h ill=%b, want pc=%h rs1=%0d rs2=%0d rd=%0d imm=%h ctrl=%h ill=%b",
                                 out_pc, out_rs1, out_rs2, out_rd, out_immext, out_ctrl, out_illegal,
                                 e.pc, e.rs1, e.rs2, e.rd, e.imm, e.ctrl, e.ill);
                    end
                    checks++;
                    if (nou_out_illegal !== e.ill_nou) begin
                        errors++;
                        $display("FAIL sb_illegal_no_utype: got %b want %b (pc=%h)", nou_out_illegal, e.ill_nou, e.pc);
                    end
                end
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back(cur_exp);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input exp_t e);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc_ctr;
        e.pc     = pc_ctr;
        cur_exp  = e;
        pc_ctr   = pc_ctr + 32'd4;
    endtask

    task automatic send(input logic [31:0] instr, input exp_t e, output int tries);
        logic acc;
        present(instr, e);
        tries = 0;
        do begin
            @(negedge clk);
            acc = in_ready && !flush;
            step();
            tries++;
        end while (!acc && tries < 20);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: instr %h not accepted after %0d cycles, want accept", instr, tries);
        end
        in_valid = 1'b0;
    endtask

    localparam logic [31:0] I_LW   = 32'hFFC4A303;
    localparam logic [31:0] I_SW   = 32'h0064A423;
    localparam logic [31:0] I_OR   = 32'h0062E233;
    localparam logic [31:0] I_BEQ  = 32'hFE420AE3;
    localparam logic [31:0] I_SUB  = 32'h403100B3;
    localparam logic [31:0] I_ADDI = 32'hFFF00293;
    localparam logic [31:0] I_SLTI = 32'h0050A313;
    localparam logic [31:0] I_JAL  = 32'h0000006F;
    localparam logic [31:0] I_LUI  = 32'h123452B7;
    localparam logic [31:0] I_ILL  = 32'h0000007F;

    exp_t e_lw, e_sw, e_or, e_beq, e_sub, e_addi, e_slti, e_jal, e_lui, e_ill;

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
        step();
        step();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || out_immext !== '0 || out_pc !== '0 ||
            out_rs1 !== '0 || out_rs2 !== '0 || out_rd !== '0 || out_illegal !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: got v=%b ctrl=%h imm=%h pc=%h ill=%b rdy=%b, want all zero and rdy=1",
                     out_valid, out_ctrl, out_immext, out_pc, out_illegal, in_ready);
        end
        step();
        reset = 1'b0;
    endtask

    task automatic test_lw();
        int t;
        out_ready = 1'b1;
        send(I_LW, e_lw, t);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_immext !== 32'hFFFFFFFC) begin
            errors++;
            $display("FAIL lw_latency: got v=%b imm=%h, want v=1 imm=fffffffc", out_valid, out_immext);
        end
        step();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== '0) begin
            errors++;
            $display("FAIL bubble: got v=%b ctrl=%h, want v=0 ctrl=0", out_valid, out_ctrl);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int t1, t2, t3;
        out_ready = 1'b1;
        send(I_SW, e_sw, t1);
        send(I_OR, e_or, t2);
        send(I_BEQ, e_beq, t3);
        checks++;
        if (t1 != 1 || t2 != 1 || t3 != 1) begin
            errors++;
            $display("FAIL b2b_throughput: got tries %0d/%0d/%0d, want 1/1/1", t1, t2, t3);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_ctrl.branch !== 1'b1 || out_immext !== 32'hFFFFFFF4) begin
            errors++;
            $display("FAIL b2b_beq: got v=%b br=%b imm=%h, want v=1 br=1 imm=fffffff4", out_valid, out_ctrl.branch, out_immext);
        end
        step();
        step();
    endtask

    task automatic test_stall();
        logic [92:0] snap;
        out_ready = 1'b0;
        present(I_SUB, e_sub);
        step();
        present(I_ADDI, e_addi);
        snap = {out_valid, out_pc, out_rs1, out_rs2, out_rd, out_immext, out_ctrl, out_illegal};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
                {out_valid, out_pc, out_rs1, out_rs2, out_rd, out_immext, out_ctrl, out_illegal} !== snap) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d got rdy=%b v=%b pc=%h ctrl=%h, want rdy=0 v=1 and outputs unchanged",
                         i, in_ready, out_valid, out_pc, out_ctrl);
            end
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        step();
        present(I_SLTI, e_slti);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_rd !== 5'd5) begin
            errors++;
            $display("FAIL stall_release: got v=%b rd=%0d, want v=1 rd=5", out_valid, out_rd);
        end
        step();
        in_valid = 1'b0;
        step();
        step();
    endtask

    task automatic test_flush();
        int t;
        out_ready = 1'b0;
        send(I_ADDI, e_addi, t);
        present(I_SW, e_sw);
        flush = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== '0) begin
            errors++;
            $display("FAIL flush_held: got v=%b ctrl=%h, want v=0 ctrl=0", out_valid, out_ctrl);
        end
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop: got v=%b, want v=0 after flush with in_ready=1", out_valid);
        end
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic test_jal_lui_ill();
        int t;
        out_ready = 1'b1;
        send(I_JAL, e_jal, t);
        send(I_LUI, e_lui, t);
        @(negedge clk);
        checks++;
        if (out_immext !== 32'h12345000 || out_ctrl.alu_control !== ALU_PASSB || nou_out_illegal !== 1'b1) begin
            errors++;
            $display("FAIL lui: got imm=%h alu=%h nou_ill=%b, want imm=12345000 alu=4 nou_ill=1",
                     out_immext, out_ctrl.alu_control, nou_out_illegal);
        end
        step();
        present(I_ILL, e_ill);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_illegal !== 1'b1 || out_ctrl !== '0) begin
            errors++;
            $display("FAIL illegal: got ill=%b ctrl=%h, want ill=1 ctrl=0", out_illegal, out_ctrl);
        end
        step();
        step();
    endtask

    task automatic test_reset_stall();
        int t;
        out_ready = 1'b0;
        send(I_ADDI, e_addi, t);
        present(I_SW, e_sw);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || out_immext !== '0 || out_pc !== '0 ||
            out_rs1 !== '0 || out_rs2 !== '0 || out_rd !== '0 || out_illegal !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall: got v=%b ctrl=%h imm=%h pc=%h rd=%0d rdy=%b, want all zero and rdy=1",
                     out_valid, out_ctrl, out_immext, out_pc, out_rd, in_ready);
        end
        step();
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
    endtask

    initial begin
        e_lw   = mk(5'd9, 5'd28, 5'd6, 32'hFFFFFFFC, 1'b1, mkc(1, RES_MEM, 0, 1, 0, 0, 0, 0, ALU_ADD), 0, 0);
        e_sw   = mk(5'd9, 5'd6, 5'd8, 32'h00000008, 1'b1, mkc(0, RES_ALU, 1, 1, 0, 0, 0, 0, ALU_ADD), 0, 0);
        e_or   = mk(5'd5, 5'd6, 5'd4, 32'h0, 1'b0, mkc(1, RES_ALU, 0, 0, 0, 0, 0, 0, ALU_OR), 0, 0);
        e_beq  = mk(5'd4, 5'd4, 5'd21, 32'hFFFFFFF4, 1'b1, mkc(0, RES_ALU, 0, 0, 0, 1, 0, 0, ALU_SUB), 0, 0);
        e_sub  = mk(5'd2, 5'd3, 5'd1, 32'h0, 1'b0, mkc(1, RES_ALU, 0, 0, 0, 0, 0, 0, ALU_SUB), 0, 0);
        e_addi = mk(5'd0, 5'd31, 5'd5, 32'hFFFFFFFF, 1'b1, mkc(1, RES_ALU, 0, 1, 0, 0, 0, 0, ALU_ADD), 0, 0);
        e_slti = mk(5'd1, 5'd5, 5'd6, 32'h00000005, 1'b1, mkc(1, RES_ALU, 0, 1, 0, 0, 0, 0, ALU_SLT), 0, 0);
        e_jal  = mk(5'd0, 5'd0, 5'd0, 32'h0, 1'b1, mkc(1, RES_PC4, 0, 0, 0, 0, 1, 0, ALU_ADD), 0, 0);
        e_lui  = mk(5'd8, 5'd3, 5'd5, 32'h12345000, 1'b1, mkc(1, RES_ALU, 0, 1, 0, 0, 0, 0, ALU_PASSB), 0, 1);
        e_ill  = mk(5'd0, 5'd0, 5'd0, 32'h0, 1'b0, '0, 1, 1);

        test_reset();
        test_lw();
        test_back_to_back();
        test_stall();
        test_flush();
        test_jal_lui_ill();
        test_reset_stall();

        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expectations, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
